mdu_issue_controller: RTL and testbench

Issue stage directly upstream of the multiplication/division unit (MDU). Accepts one HI/LO instruction per cycle from the execute stage, stalls the pipeline while the MDU is busy, drives the MDU operation/operand/start inputs safely (the MDU writes HI/LO on its operation code alone), and registers MFHI/MFLO results into a one-cycle writeback pulse. It also keeps a stall-cycle statistic and a sticky watchdog flag for hung MDU operations.

---
 rtl/mdu_issue_if.sv | 37 +++
 rtl/mdu_issue_controller.sv | 99 +++++++++
 tb/tb_mdu_issue_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_issue_if.sv
// Request, MDU-drive and writeback signals between the execute stage, the MDU issue controller and the MDU.
interface mdu_issue_if;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;

  logic              reqValid;
  logic [OP_W-1:0]   reqOp;
  logic [XLEN-1:0]   reqOperand1;
  logic [XLEN-1:0]   reqOperand2;
  logic [REG_W-1:0]  reqDest;
  logic              flush;
  logic              stall;
  logic [OP_W-1:0]   mduOperation;
  logic [XLEN-1:0]   mduOperand1;
  logic [XLEN-1:0]   mduOperand2;
  logic              mduStart;
  logic              mduBusy;
  logic [XLEN-1:0]   mduDataRead;
  logic              wbValid;
  logic [REG_W-1:0]  wbDest;
  logic [XLEN-1:0]   wbData;
  logic [XLEN-1:0]   stallCycles;
  logic              timeoutError;

  modport slave (
    input  reqValid, reqOp, reqOperand1, reqOperand2, reqDest, flush, mduBusy, mduDataRead,
    output stall, mduOperation, mduOperand1, mduOperand2, mduStart,
           wbValid, wbDest, wbData, stallCycles, timeoutError
  );

  modport master (
    output reqValid, reqOp, reqOperand1, reqOperand2, reqDest, flush, mduBusy, mduDataRead,
    input  stall, mduOperation, mduOperand1, mduOperand2, mduStart,
           wbValid, wbDest, wbData, stallCycles, timeoutError
  );
endinterface

// File: rtl/mdu_issue_controller.sv
// Issue stage in front of the MDU: gates MDU op/start, stalls while busy, registers HI/LO reads
// into a writeback pulse, and tracks stall statistics plus a sticky hung-operation watchdog.
module mdu_issue_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input logic       clock,
  input logic       reset,
  mdu_issue_if.slave bus
);
  localparam int unsigned XLEN     = 32;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned STREAK_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, STALLED} state_t;

  state_t              state, state_next;
  logic [STREAK_W-1:0] streak, streak_next;
  logic                timeout_hit;
  logic                accept, stall_now, read_issue;
  logic                wb_valid;
  logic [REG_W-1:0]    wb_dest;
  logic [XLEN-1:0]     wb_data;
  logic [XLEN-1:0]     stall_cycles;
  logic                timeout_error;

  assign accept     = bus.reqValid & ~bus.flush & ~bus.mduBusy;
  assign stall_now  = bus.reqValid & ~bus.flush &  bus.mduBusy;
  assign read_issue = accept & ~bus.reqOp[2] & ~bus.reqOp[1];

  // Idle MDU sees READ_HI with zero operands: the MDU commits HI/LO writes on op code alone.
  assign bus.stall        = stall_now;
  assign bus.mduOperation = accept ? bus.reqOp : OP_W'(0);
  assign bus.mduOperand1  = accept ? bus.reqOperand1 : XLEN'(0);
  assign bus.mduOperand2  = accept ? bus.reqOperand2 : XLEN'(0);
  assign bus.mduStart     = accept & bus.reqOp[2];

  assign bus.wbValid      = wb_valid;
  assign bus.wbDest       = wb_dest;
  assign bus.wbData       = wb_data;
  assign bus.stallCycles  = stall_cycles;
  assign bus.timeoutError = timeout_error;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
    end
  end

  // Stall-streak FSM; the streak saturates at the watchdog threshold.
  always_comb begin
    state_next  = state;
    streak_next = streak;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (stall_now) begin
          state_next  = STALLED;
          streak_next = STREAK_W'(1);
        end
      end
      STALLED: begin
        if (stall_now) begin
          if (streak < STREAK_W'(TIMEOUT_CYCLES)) streak_next = streak + STREAK_W'(1);
        end else begin
          state_next  = IDLE;
          streak_next = '0;
        end
      end
      default: begin
        state_next  = IDLE;
        streak_next = '0;
      end
    endcase
    if (streak_next == STREAK_W'(TIMEOUT_CYCLES)) timeout_hit = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_valid      <= 1'b0;
      wb_dest       <= '0;
      wb_data       <= '0;
      stall_cycles  <= '0;
      timeout_error <= 1'b0;
    end else begin
      wb_valid <= read_issue;
      if (read_issue) begin
        wb_dest <= bus.reqDest;
        wb_data <= bus.mduDataRead;
      end
      if (stall_now && (stall_cycles != '1)) stall_cycles <= stall_cycles + XLEN'(1);
      if (timeout_hit) timeout_error <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mdu_issue_controller.sv
// Directed bench for mdu_issue_controller with a behavioural MDU (5-cycle mul, 10-cycle div).
module tb_mdu_issue_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mdu_issue_if ifc ();

  mdu_issue_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  // Behavioural MDU: results committed at start, busy for 5/10 cycles, writes on op code alone.
  logic [31:0] hi, lo;
  int          busy_cnt;
  logic [63:0] smul, umul;
  assign smul = $signed({{32{ifc.mduOperand1[31]}}, ifc.mduOperand1}) *
                $signed({{32{ifc.mduOperand2[31]}}, ifc.mduOperand2});
  assign umul = {32'd0, ifc.mduOperand1} * {32'd0, ifc.mduOperand2};
  assign ifc.mduBusy     = (busy_cnt != 0);
  assign ifc.mduDataRead = (ifc.mduOperation == 3'd1) ? lo : hi;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi <= 32'd0; lo <= 32'd0; busy_cnt <= 0;
    end else begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (ifc.mduStart) begin
        busy_cnt <= ifc.mduOperation[1] ? 10 : 5;
        case (ifc.mduOperation)
          3'd4: {hi, lo} <= smul;
          3'd5: {hi, lo} <= umul;
          3'd6: if (ifc.mduOperand2 != 0) begin
                  lo <= $signed(ifc.mduOperand1) / $signed(ifc.mduOperand2);
                  hi <= $signed(ifc.mduOperand1) % $signed(ifc.mduOperand2);
                end
          default: if (ifc.mduOperand2 != 0) begin
                  lo <= ifc.mduOperand1 / ifc.mduOperand2;
                  hi <= ifc.mduOperand1 % ifc.mduOperand2;
                end
        endcase
      end else if (ifc.mduOperation == 3'd2) hi <= ifc.mduOperand1;
      else if (ifc.mduOperation == 3'd3) lo <= ifc.mduOperand1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic f);
    ifc.reqValid = v; ifc.reqOp = op; ifc.reqOperand1 = a;
    ifc.reqOperand2 = b; ifc.reqDest = d; ifc.flush = f;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ticks while stalled, bounded; returns number of stalled cycles seen.
  task automatic wait_stall(output int n);
    n = 0;
    while (ifc.stall && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (ifc.mduBusy && n < 40) begin
      tick();
      n++;
    end
    check("mdu_idle", 32'(ifc.mduBusy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int   n;
    logic bad_op;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_wbValid", 32'(ifc.wbValid), 32'd0);
    check("rst_wbDest", 32'(ifc.wbDest), 32'd0);
    check("rst_wbData", ifc.wbData, 32'd0);
    check("rst_stallCycles", ifc.stallCycles, 32'd0);
    check("rst_timeout", 32'(ifc.timeoutError), 32'd0);
    check("rst_mduOp", 32'(ifc.mduOperation), 32'd0);
    reset = 1'b1;
    tick();

    // 7*6 then read LO
    drive(1, 3'd4, 32'd7, 32'd6, 5'd0, 0); #1;
    check("mul_start", 32'(ifc.mduStart), 32'd1);
    check("mul_op", 32'(ifc.mduOperation), 32'd4);
    check("mul_nostall", 32'(ifc.stall), 32'd0);
    tick();
    drive(1, 3'd1, 32'd0, 32'd0, 5'd9, 0); #1;
    check("rdlo_stall", 32'(ifc.stall), 32'd1);
    check("rdlo_op_gated", 32'(ifc.mduOperation), 32'd0);
    wait_stall(n);
    check("mul_stall_len", 32'(n), 32'd5);
    check("rdlo_issue_op", 32'(ifc.mduOperation), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    check("mul_wbValid", 32'(ifc.wbValid), 32'd1);
    check("mul_wbDest", 32'(ifc.wbDest), 32'd9);
    check("mul_wbData", ifc.wbData, 32'd42);
    check("mul_stallCycles", ifc.stallCycles, 32'd5);
    check("mul_timeout", 32'(ifc.timeoutError), 32'd1);
    tick();
    check("wb_pulse_end", 32'(ifc.wbValid), 32'd0);
    check("wb_data_hold", ifc.wbData, 32'd42);

    // -7 / 2 signed, read HI = remainder -1
    drive(1, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd0, 0); #1;
    check("div_start", 32'(ifc.mduStart), 32'd1);
    tick();
    drive(1, 3'd0, 32'd0, 32'd0, 5'd3, 0); #1;
    wait_stall(n);
    check("div_stall_len", 32'(n), 32'd10);
    tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    check("div_wbValid", 32'(ifc.wbValid), 32'd1);
    check("div_wbDest", 32'(ifc.wbDest), 32'd3);
    check("div_wbData", ifc.wbData, 32'hFFFF_FFFF);
    check("div_stallCycles", ifc.stallCycles, 32'd15);

    // Unsigned divide by zero leaves HI/LO unchanged
    drive(1, 3'd7, 32'd5, 32'd0, 5'd0, 0); #1;
    tick();
    drive(1, 3'd0, 32'd0, 32'd0, 5'd3, 0); #1;
    wait_stall(n);
    check("divz_stall_len", 32'(n), 32'd10);
    tick();
    drive(1, 3'd1, 32'd0, 32'd0, 5'd6, 0); #1;
    check("divz_hi", ifc.wbData, 32'hFFFF_FFFF);
    tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    check("divz_lo", ifc.wbData, 32'hFFFF_FFFD);
    check("divz_wbDest", 32'(ifc.wbDest), 32'd6);
    check("divz_stallCycles", ifc.stallCycles, 32'd25);

    // WRITE_HI held while busy must not reach the MDU early
    drive(1, 3'd5, 32'd2, 32'd3, 5'd0, 0); #1;
    tick();
    drive(1, 3'd2, 32'h1234, 32'd0, 5'd0, 0); #1;
    bad_op = 1'b0;
    n = 0;
    while (ifc.stall && n < 40) begin
      if (ifc.mduOperation != 3'd0) bad_op = 1'b1;
      tick();
      n++;
    end
    check("wr_gate_busy", 32'(bad_op), 32'd0);
    check("wr_stall_len", 32'(n), 32'd5);
    check("wr_issue_op", 32'(ifc.mduOperation), 32'd2);
    check("wr_issue_opnd", ifc.mduOperand1, 32'h1234);
    tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    check("wr_one_cycle", 32'(ifc.mduOperation), 32'd0);
    drive(1, 3'd0, 32'd0, 32'd0, 5'd4, 0); #1;
    tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    check("wr_readback", ifc.wbData, 32'h1234);
    check("wr_stallCycles", ifc.stallCycles, 32'd30);

    // Flush suppresses start and writeback; flush beats busy
    drive(1, 3'd4, 32'd3, 32'd3, 5'd0, 1); #1;
    check("flush_start", 32'(ifc.mduStart), 32'd0);
    tick();
    check("flush_nobusy", 32'(ifc.mduBusy), 32'd0);
    drive(1, 3'd1, 32'd0, 32'd0, 5'd7, 1); #1;
    tick();
    check("flush_rd", 32'(ifc.wbValid), 32'd0);
    drive(1, 3'd4, 32'd1, 32'd1, 5'd0, 0); #1;
    tick();
    drive(1, 3'd1, 32'd0, 32'd0, 5'd7, 1); #1;
    check("flush_wins", 32'(ifc.stall), 32'd0);
    wait_idle();
    drive(0, 0, 0, 0, 0, 0); #1;
    check("flush_stallCycles", ifc.stallCycles, 32'd30);

    // Watchdog with threshold 4
    reset = 1'b0; #1;
    reset = 1'b1;
    check("wd_rst_stall", ifc.stallCycles, 32'd0);
    check("wd_rst_timeout", 32'(ifc.timeoutError), 32'd0);
    tick();
    drive(1, 3'd6, 32'd1, 32'd1, 5'd0, 0); #1;
    tick();
    drive(1, 3'd1, 32'd0, 32'd0, 5'd2, 0); #1;
    check("wd_stall", 32'(ifc.stall), 32'd1);
    repeat (3) tick();
    check("wd_3", 32'(ifc.timeoutError), 32'd0);
    tick();
    check("wd_4", 32'(ifc.timeoutError), 32'd1);
    drive(0, 0, 0, 0, 0, 0); #1;
    wait_idle();
    check("wd_sticky", 32'(ifc.timeoutError), 32'd1);
    check("wd_stallCycles", ifc.stallCycles, 32'd4);
    drive(1, 3'd1, 32'd0, 32'd0, 5'd2, 0); #1;
    tick();
    drive(0, 0, 0, 0, 0, 0); #1;
    check("wd_rdlo", ifc.wbData, 32'd1);

    // Async reset during a stall streak
    drive(1, 3'd5, 32'd1, 32'd1, 5'd0, 0); #1;
    tick();
    drive(1, 3'd0, 32'd0, 32'd0, 5'd1, 0); #1;
    tick();
    tick();
    check("ar_pre_stall", ifc.stallCycles, 32'd6);
    reset = 1'b0; #1;
    check("ar_wbValid", 32'(ifc.wbValid), 32'd0);
    check("ar_wbDest", 32'(ifc.wbDest), 32'd0);
    check("ar_wbData", ifc.wbData, 32'd0);
    check("ar_stallCycles", ifc.stallCycles, 32'd0);
    check("ar_timeout", 32'(ifc.timeoutError), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
